lstm_cell_seq: RTL and testbench
================================

LSTM_CELL_SEQ -- requirements
Module: lstm_cell_seq

Interface
REQ-001 Parameter X_DIM, default 8, input vector length in int8 elements (1..64).
REQ-002 Parameter H_DIM, default 8, hidden/cell state length in int8 elements (1..64).
REQ-003 Parameter ACC_W, default 24, signed accumulator width; SHALL be at least 17+clog2(X_DIM+H_DIM).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 iW_we  input  1  weight-store write strobe.
REQ-007 iW_addr  input  clog2(4*H_DIM*K)  weight address, with K=X_DIM+H_DIM.
REQ-008 iW_data  input  8  signed weight, Q1.7.
REQ-009 iB_we  input  1  bias-store write strobe.
REQ-010 iB_addr  input  clog2(4*H_DIM)  bias address.
REQ-011 iB_data  input  16  signed bias, Q2.14.
REQ-012 iLoad_valid  input  1  load Ct/Ht state.
REQ-013 iCt_load, iHt_load  input  8*H_DIM each  state to load; element n at bits [8n+7:8n].
REQ-014 iNext_valid  input  1  request one timestep.
REQ-015 iData  input  8*X_DIM  input vector x; element n at [8n+7:8n].
REQ-016 oReady  output  1  high exactly when FSM is IDLE.
REQ-017 oLstm_done  output  1  one-cycle completion pulse.
REQ-018 oCt, oHt  output  8*H_DIM each  committed cell/hidden state, registered.

Function
REQ-019 Weight address SHALL be (j*4+g)*K+k; bias address j*4+g; j=hidden unit, g=0 i, 1 f, 2 g(cell), 3 o; k<X_DIM selects x[k], else h_old[k-X_DIM].
REQ-020 Weight/bias writes SHALL take effect only in IDLE; writes in any other state are ignored. Stores are read combinationally.
REQ-021 A step is accepted on a clock edge with iNext_valid=1 and oReady=1; iData is captured at that edge; iNext_valid while busy is ignored.
REQ-022 iLoad_valid in IDLE SHALL overwrite committed Ct/Ht; when coincident with acceptance, loaded values are used by that step. Ignored when busy.
REQ-023 FSM states: IDLE, MAC, ACT, UPDATE, DONE. IDLE->MAC on accept; per unit j, per gate g: K MAC cycles then one ACT cycle; after g=3, one UPDATE cycle; after j=H_DIM-1 UPDATE -> DONE -> IDLE.
REQ-024 MAC: first cycle acc=bias+w*in, subsequent acc+=w*in; signed ACC_W arithmetic, no intermediate saturation.
REQ-025 ACT sigmoid (g=0,1,3): clamp(((acc>>>2)+8192)>>>7, 0, 127). ACT tanh (g=2): clamp(acc>>>7, -128, 127).
REQ-026 UPDATE: c=sat8((f*c_old + i*gc)>>>7); h=sat8((o*clamp(c,-128,127))>>>7); >>> is arithmetic shift (truncating), sat8 clamps to [-128,127].
REQ-027 New c/h SHALL be written to shadow buffers; all MACs of a step use h_old; shadows commit to oCt/oHt at the DONE cycle.
REQ-028 oLstm_done SHALL be high only during DONE, exactly H_DIM*(4K+5)+1 cycles after the accepting edge.

Reset
REQ-029 resetn=0 at a clock edge SHALL force IDLE, oLstm_done=0, oCt=0, oHt=0, shadows/accumulator/counters=0, aborting any step without a done pulse.
REQ-030 Weight and bias stores SHALL NOT be cleared by reset.
REQ-031 oReady=1 from the first edge after reset assertion.

Configuration
REQ-032 Macro LSTM_CELL_SAT_STATUS_EN defined: adds output oSat_cnt (16 bits), incremented once per ACT/UPDATE clamp event that changes a value, saturating at 65535, cleared by reset and on each accept.
REQ-033 Macro undefined: oSat_cnt port and logic SHALL be absent; all other behaviour identical.

Verification (X_DIM=2, H_DIM=2, K=4, latency 43)
REQ-034 All weights/biases 0, load Ct=Ht=0x40 per element, accept step -> i=f=o=64, gc=0, oCt elements 0x20, oHt elements 0x10, done at cycle 43.
REQ-035 All biases 32767, weights 0, Ct load 0x7F -> oCt 0x7F, oHt 0x7E; with macro, oSat_cnt nonzero.
REQ-036 iNext_valid held high during busy -> oReady=0, exactly one done pulse per accepted step, no re-accept before IDLE.
REQ-037 Assert resetn=0 at cycle 20 of a step -> no done pulse, oCt=oHt=0, oReady=1; rerun without rewriting weights -> same result as REQ-034 flow.
REQ-038 iW_we with new data during MAC -> weight unchanged; result equals run without the write.

Source files
------------

// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: sequential int8 LSTM cell with one multiply-accumulate per cycle.
// Latency: oLstm_done is high in the H_DIM*(4K+5)+1-th cycle after the accepting edge (K=X_DIM+H_DIM).
// Backpressure: oReady is low while busy. iNext_valid, iLoad_valid and store writes are ignored then.
// Ports: clk, resetn (synchronous, active-low); iW_*/iB_* weight/bias store write ports;
//   iLoad_valid/iCt_load/iHt_load load the committed state; iNext_valid/iData request a timestep;
//   oReady, oLstm_done, oCt, oHt (committed state, registered).
//   Defining LSTM_CELL_SAT_STATUS_EN adds oSat_cnt, a saturating count of clamp events in the current step.
module lstm_cell_seq #(
  parameter int X_DIM = 8,
  parameter int H_DIM = 8,
  parameter int ACC_W = 24,
  localparam int K    = X_DIM + H_DIM,
  localparam int WA_W = $clog2(4 * H_DIM * K),
  localparam int BA_W = $clog2(4 * H_DIM)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               iW_we,
  input  logic [WA_W-1:0]    iW_addr,
  input  logic [7:0]         iW_data,
  input  logic               iB_we,
  input  logic [BA_W-1:0]    iB_addr,
  input  logic [15:0]        iB_data,
  input  logic               iLoad_valid,
  input  logic [8*H_DIM-1:0] iCt_load,
  input  logic [8*H_DIM-1:0] iHt_load,
  input  logic               iNext_valid,
  input  logic [8*X_DIM-1:0] iData,
  output logic               oReady,
  output logic               oLstm_done,
`ifdef LSTM_CELL_SAT_STATUS_EN
  output logic [15:0]        oSat_cnt,
`endif
  output logic [8*H_DIM-1:0] oCt,
  output logic [8*H_DIM-1:0] oHt
);

  typedef enum logic [2:0] {IDLE, MAC, ACT, UPDATE, DONE} state_t;

  localparam logic [7:0] K_LAST = 8'(K - 1);
  localparam logic [6:0] J_LAST = 7'(H_DIM - 1);

  state_t state, stateNext;

  // The weight and bias stores have no reset, so their contents survive a reset.
  logic signed [7:0]  wMem [4*H_DIM*K];
  logic signed [15:0] bMem [4*H_DIM];

  logic signed [7:0] xReg  [X_DIM];
  logic signed [7:0] ctReg [H_DIM];
  logic signed [7:0] htReg [H_DIM];
  logic signed [7:0] ctSh  [H_DIM];
  logic signed [7:0] htSh  [H_DIM];
  logic signed [7:0] gate  [4];
  logic signed [ACC_W-1:0] acc;
  logic [7:0] kCnt;
  logic [1:0] gCnt;
  logic [6:0] jCnt;

  logic [WA_W-1:0] wIdx;
  logic [BA_W-1:0] bIdx;
  logic signed [7:0]       inVal, cOld, actVal, cNew, hNew;
  logic signed [15:0]      prod, prodF, prodI, hProd, hShift;
  logic signed [ACC_W-1:0] accSum, sigSh, tanhSh;
  logic signed [17:0]      cSum, cShift;

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (iW_we) wMem[iW_addr] <= iW_data;
      if (iB_we) bMem[iB_addr] <= iB_data;
    end
  end

  always_comb begin
    bIdx  = BA_W'({jCnt, gCnt});
    wIdx  = WA_W'(32'({jCnt, gCnt}) * 32'(K) + 32'(kCnt));
    // The MAC operand is x[k] for the first X_DIM slots and then the committed h.
    inVal = '0;
    for (int n = 0; n < X_DIM; n++) if (kCnt == 8'(n)) inVal = xReg[n];
    for (int n = 0; n < H_DIM; n++) if (kCnt == 8'(X_DIM + n)) inVal = htReg[n];
    cOld = '0;
    for (int n = 0; n < H_DIM; n++) if (jCnt == 7'(n)) cOld = ctReg[n];

    prod   = wMem[wIdx] * inVal;
    accSum = ((kCnt == 8'd0) ? ACC_W'(bMem[bIdx]) : acc) + ACC_W'(prod);

    sigSh  = ((acc >>> 2) + ACC_W'(8192)) >>> 7;
    tanhSh = acc >>> 7;
    actVal = '0;
    if (gCnt == 2'd2) begin
      if (tanhSh > ACC_W'(127))       actVal = 8'sd127;
      else if (tanhSh < ACC_W'(-128)) actVal = 8'h80;
      else                            actVal = tanhSh[7:0];
    end else begin
      if (sigSh < ACC_W'(0))          actVal = 8'sd0;
      else if (sigSh > ACC_W'(127))   actVal = 8'sd127;
      else                            actVal = sigSh[7:0];
    end

    // gate[0]=i, gate[1]=f, gate[2]=g (cell candidate), gate[3]=o
    prodF  = gate[1] * cOld;
    prodI  = gate[0] * gate[2];
    cSum   = 18'(prodF) + 18'(prodI);
    cShift = cSum >>> 7;
    if (cShift > 18'(127))       cNew = 8'sd127;
    else if (cShift < 18'(-128)) cNew = 8'h80;
    else                         cNew = cShift[7:0];
    // cNew is already within int8, so it needs no further clamp before the h product.
    hProd  = gate[3] * cNew;
    hShift = hProd >>> 7;
    if (hShift > 16'(127))       hNew = 8'sd127;
    else if (hShift < 16'(-128)) hNew = 8'h80;
    else                         hNew = hShift[7:0];
  end

  always_comb begin
    stateNext  = state;
    oReady     = (state == IDLE);
    oLstm_done = (state == DONE);
    case (state)
      IDLE:    if (iNext_valid) stateNext = MAC;
      MAC:     if (kCnt == K_LAST) stateNext = ACT;
      ACT:     stateNext = (gCnt == 2'd3) ? UPDATE : MAC;
      UPDATE:  stateNext = (jCnt == J_LAST) ? DONE : MAC;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
      kCnt  <= '0;
      gCnt  <= '0;
      jCnt  <= '0;
      for (int n = 0; n < 4; n++) gate[n] <= '0;
      for (int n = 0; n < X_DIM; n++) xReg[n] <= '0;
      for (int n = 0; n < H_DIM; n++) begin
        ctReg[n] <= '0;
        htReg[n] <= '0;
        ctSh[n]  <= '0;
        htSh[n]  <= '0;
      end
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          // A load in the same cycle as an accept is what the new step sees.
          if (iLoad_valid) begin
            for (int n = 0; n < H_DIM; n++) begin
              ctReg[n] <= iCt_load[8*n +: 8];
              htReg[n] <= iHt_load[8*n +: 8];
            end
          end
          if (iNext_valid) begin
            for (int n = 0; n < X_DIM; n++) xReg[n] <= iData[8*n +: 8];
            kCnt <= '0;
            gCnt <= '0;
            jCnt <= '0;
          end
        end
        MAC: begin
          acc  <= accSum;
          kCnt <= (kCnt == K_LAST) ? 8'd0 : kCnt + 8'd1;
        end
        ACT: begin
          gate[gCnt] <= actVal;
          gCnt       <= gCnt + 2'd1;
        end
        UPDATE: begin
          // New c/h go to shadows so later units still read the old committed h and c.
          for (int n = 0; n < H_DIM; n++) begin
            if (jCnt == 7'(n)) begin
              ctSh[n] <= cNew;
              htSh[n] <= hNew;
            end
          end
          jCnt <= jCnt + 7'd1;
        end
        DONE: begin
          for (int n = 0; n < H_DIM; n++) begin
            ctReg[n] <= ctSh[n];
            htReg[n] <= htSh[n];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar n = 0; n < H_DIM; n++) begin : gPack
    assign oCt[8*n +: 8] = ctReg[n];
    assign oHt[8*n +: 8] = htReg[n];
  end

`ifdef LSTM_CELL_SAT_STATUS_EN
  logic [1:0]  satInc;
  logic [15:0] satCnt;
  logic [16:0] satSum;

  // Counts clamps that actually changed a value; UPDATE can contribute two (c and h).
  always_comb begin
    satInc = '0;
    if (state == ACT) begin
      if (gCnt == 2'd2) satInc = 2'((tanhSh > ACC_W'(127)) || (tanhSh < ACC_W'(-128)));
      else              satInc = 2'((sigSh > ACC_W'(127)) || (sigSh < ACC_W'(0)));
    end else if (state == UPDATE) begin
      satInc = 2'((cShift > 18'(127)) || (cShift < 18'(-128)))
             + 2'((hShift > 16'(127)) || (hShift < 16'(-128)));
    end
    satSum = 17'(satCnt) + 17'(satInc);
  end

  always_ff @(posedge clk) begin
    if (!resetn)                         satCnt <= '0;
    else if (state == IDLE && iNext_valid) satCnt <= '0;
    else                                 satCnt <= satSum[16] ? 16'hFFFF : satSum[15:0];
  end

  assign oSat_cnt = satCnt;
`endif

endmodule

// File: tb/tb_lstm_cell_seq.sv
// tb_lstm_cell_seq: randomized and directed checks of lstm_cell_seq (X_DIM=2, H_DIM=2)
// against an integer LSTM reference model kept in this bench.
module tb_lstm_cell_seq;
  localparam int XD = 2;
  localparam int HD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iW_we, iB_we, iLoad_valid, iNext_valid;
  logic [4:0]  iW_addr;
  logic [7:0]  iW_data;
  logic [2:0]  iB_addr;
  logic [15:0] iB_data;
  logic [15:0] iCt_load, iHt_load, iData;
  logic        oReady, oLstm_done;
  logic [15:0] oCt, oHt;
`ifdef LSTM_CELL_SAT_STATUS_EN
  logic [15:0] oSat_cnt;
`endif

  int nChk = 0;
  int nFail = 0;
  int wm[32];
  int bm[8];
  int mc[2];
  int mh[2];
  int satExp;

  always #5 clk = ~clk;

  lstm_cell_seq #(.X_DIM(XD), .H_DIM(HD), .ACC_W(24)) dut (
    .clk(clk), .resetn(resetn),
    .iW_we(iW_we), .iW_addr(iW_addr), .iW_data(iW_data),
    .iB_we(iB_we), .iB_addr(iB_addr), .iB_data(iB_data),
    .iLoad_valid(iLoad_valid), .iCt_load(iCt_load), .iHt_load(iHt_load),
    .iNext_valid(iNext_valid), .iData(iData),
    .oReady(oReady), .oLstm_done(oLstm_done),
`ifdef LSTM_CELL_SAT_STATUS_EN
    .oSat_cnt(oSat_cnt),
`endif
    .oCt(oCt), .oHt(oHt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    if (v < lo) begin satExp++; return lo; end
    if (v > hi) begin satExp++; return hi; end
    return v;
  endfunction

  // One LSTM timestep on the committed model state, straight from the cell equations.
  function automatic void modelStep(input logic [15:0] x);
    int inV[4];
    int gv[4];
    int nc[2];
    int nh[2];
    int acc;
    int t;
    satExp = 0;
    inV[0] = int'($signed(x[7:0]));
    inV[1] = int'($signed(x[15:8]));
    inV[2] = mh[0];
    inV[3] = mh[1];
    for (int j = 0; j < HD; j++) begin
      for (int g = 0; g < 4; g++) begin
        acc = bm[j*4+g];
        for (int k = 0; k < 4; k++) acc += wm[(j*4+g)*4+k] * inV[k];
        if (g == 2) gv[g] = sat(acc >>> 7, -128, 127);
        else        gv[g] = sat(((acc >>> 2) + 8192) >>> 7, 0, 127);
      end
      nc[j] = sat((gv[1]*mc[j] + gv[0]*gv[2]) >>> 7, -128, 127);
      nh[j] = sat((gv[3]*nc[j]) >>> 7, -128, 127);
    end
    mc = nc;
    mh = nh;
  endfunction

  function automatic logic [15:0] pk(input int a[2]);
    logic [7:0] lo, hi;
    lo = 8'(a[0]);
    hi = 8'(a[1]);
    return {hi, lo};
  endfunction

  task automatic wrW(input int a, input int d);
    iW_we = 1'b1; iW_addr = 5'(a); iW_data = 8'(d);
    wm[a] = int'($signed(iW_data));
    @(negedge clk);
    iW_we = 1'b0;
  endtask

  task automatic wrB(input int a, input int d);
    iB_we = 1'b1; iB_addr = 3'(a); iB_data = 16'(d);
    bm[a] = int'($signed(iB_data));
    @(negedge clk);
    iB_we = 1'b0;
  endtask

  // Runs one step; wrAt>0 drives store writes and a state load while busy (all must be ignored).
  task automatic doStep(input logic [15:0] x, input bit ld, input logic [15:0] cl,
                        input logic [15:0] hl, input int wrAt);
    int lat;
    int readyBusy;
    chk("ready_pre", oReady, 1);
    iData = x; iNext_valid = 1'b1;
    iLoad_valid = ld; iCt_load = cl; iHt_load = hl;
    if (ld) begin
      for (int n = 0; n < HD; n++) begin
        mc[n] = int'($signed(cl[8*n +: 8]));
        mh[n] = int'($signed(hl[8*n +: 8]));
      end
    end
    modelStep(x);
    @(negedge clk);
    iLoad_valid = 1'b0; iNext_valid = 1'b0;
    lat = -1;
    readyBusy = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == wrAt) begin
        iW_we = 1'b1; iW_addr = 5'($urandom_range(0, 31)); iW_data = 8'($urandom);
        iB_we = 1'b1; iB_addr = 3'($urandom_range(0, 7)); iB_data = 16'($urandom);
        iLoad_valid = 1'b1; iCt_load = 16'($urandom); iHt_load = 16'($urandom);
        iNext_valid = 1'b1;
      end
      if (c == wrAt + 2) begin
        iW_we = 1'b0; iB_we = 1'b0; iLoad_valid = 1'b0; iNext_valid = 1'b0;
      end
      if (oLstm_done) begin
        lat = c;
        break;
      end
      if (oReady) readyBusy++;
      @(negedge clk);
    end
    iW_we = 1'b0; iB_we = 1'b0; iLoad_valid = 1'b0; iNext_valid = 1'b0;
    chk("latency", lat, 43);
    chk("ready_busy", readyBusy, 0);
    @(negedge clk);
    chk("oCt", oCt, pk(mc));
    chk("oHt", oHt, pk(mh));
`ifdef LSTM_CELL_SAT_STATUS_EN
    chk("sat_cnt", oSat_cnt, satExp);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, firstDone, secondDone, readyCnt;
    logic [15:0] x;
    resetn = 1'b0; iW_we = 1'b0; iB_we = 1'b0; iLoad_valid = 1'b0; iNext_valid = 1'b0;
    iW_addr = '0; iW_data = '0; iB_addr = '0; iB_data = '0;
    iCt_load = '0; iHt_load = '0; iData = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", oReady, 1);
    chk("rst_done", oLstm_done, 0);
    chk("rst_ct", oCt, 0);
    chk("rst_ht", oHt, 0);
    resetn = 1'b1;
    mc = '{0, 0};
    mh = '{0, 0};
    @(negedge clk);

    // Zero weights/biases with state 0x40: i=f=o=64, gc=0.
    for (int a = 0; a < 32; a++) wrW(a, 0);
    for (int b = 0; b < 8; b++) wrB(b, 0);
    doStep(16'($urandom), 1'b1, 16'h4040, 16'h4040, 0);
    chk("zero_ct", oCt, 16'h2020);
    chk("zero_ht", oHt, 16'h1010);

    // Reset in the middle of a step aborts it without a done pulse.
    dones = 0;
    iData = 16'($urandom); iNext_valid = 1'b1;
    iLoad_valid = 1'b1; iCt_load = 16'h4040; iHt_load = 16'h4040;
    @(negedge clk);
    iNext_valid = 1'b0; iLoad_valid = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (oLstm_done) dones++;
      @(negedge clk);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_ready", oReady, 1);
    chk("abort_done_now", oLstm_done, 0);
    chk("abort_ct", oCt, 0);
    chk("abort_ht", oHt, 0);
    for (int c = 0; c < 60; c++) begin
      if (oLstm_done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    mc = '{0, 0};
    mh = '{0, 0};
    doStep(16'($urandom), 1'b1, 16'h4040, 16'h4040, 0);
    chk("rerun_ct", oCt, 16'h2020);
    chk("rerun_ht", oHt, 16'h1010);

    // Maximum bias saturates the cell candidate and c.
    for (int b = 0; b < 8; b++) wrB(b, 32767);
    doStep(16'($urandom), 1'b1, 16'h7F7F, 16'h0000, 0);
    chk("sat_ct", oCt, 16'h7F7F);
    chk("sat_ht", oHt, 16'h7E7E);

    // Random weights, biases, inputs and state; odd passes poke the ports while busy.
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 32; a++) wrW(a, int'($urandom_range(0, 255)));
      for (int b = 0; b < 8; b++) wrB(b, int'($urandom_range(0, 65535)));
      doStep(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
             (i % 2 == 1) ? (3 + i * 5) : 0);
    end

    // iNext_valid held high: two back-to-back steps, one done pulse each.
    x = 16'($urandom);
    chk("hold_ready_pre", oReady, 1);
    iData = x; iNext_valid = 1'b1;
    modelStep(x);
    modelStep(x);
    dones = 0; firstDone = -1; secondDone = -1; readyCnt = 0;
    @(negedge clk);
    for (int c = 1; c <= 95; c++) begin
      if (oLstm_done) begin
        dones++;
        if (firstDone < 0) firstDone = c;
        else               secondDone = c;
      end
      if (oReady) readyCnt++;
      if (c == 87) iNext_valid = 1'b0;
      @(negedge clk);
    end
    iNext_valid = 1'b0;
    chk("hold_dones", dones, 2);
    chk("hold_first", firstDone, 43);
    chk("hold_second", secondDone, 87);
    chk("hold_ready_cnt", readyCnt, 9);
    chk("hold_ct", oCt, pk(mc));
    chk("hold_ht", oHt, pk(mh));

    $display("[TB] %0d tests run, %0d failed", nChk, nFail);
    $finish;
  end
endmodule
